cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 113 +++++++++++
 tb/tb_cpu_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/WRITEBACK with a fetch
// timeout that parks the core in HALT with a sticky fault flag.
module cpu_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mem_ready,
  input  logic [31:0] instr,
  input  logic [31:0] alu_result,
  input  logic        alu_neg,
  input  logic        alu_zero,
  output logic        mem_read,
  output logic        pc_en,
  output logic [31:0] ir,
  output logic [3:0]  alu_op,
  output logic [31:0] res_q,
  output logic [1:0]  flags_q,
  output logic        res_valid,
  output logic        halted,
  output logic        fault,
  output logic [15:0] instr_count,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  wait_q;
  logic [31:0] ir_q;
  logic [3:0]  alu_op_q;
  logic [31:0] result_q;
  logic [1:0]  flag_q;
  logic [15:0] count_q;
  logic        fault_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wait_q   <= 8'd0;
      ir_q     <= 32'd0;
      alu_op_q <= 4'd0;
      result_q <= 32'd0;
      flag_q   <= 2'd0;
      count_q  <= 16'd0;
      fault_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ready) begin
            ir_q    <= instr;
            wait_q  <= 8'd0;
            state_q <= S_DECODE;
          end else if (wait_q == WAIT_LAST) begin
            // The cycle that would reach TIMEOUT waits is the last one spent in FETCH.
            wait_q  <= 8'd0;
            fault_q <= 1'b1;
            state_q <= S_HALT;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        S_DECODE: begin
          alu_op_q <= ir_q[31:28];
          if (ir_q[31:28] == 4'hF) state_q <= S_HALT;
          else                     state_q <= S_EXECUTE;
        end
        S_EXECUTE: begin
          state_q <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          result_q <= alu_result;
          flag_q   <= {alu_neg, alu_zero};
          if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
          state_q  <= S_FETCH;
        end
        S_HALT: begin
          if (start) begin
            fault_q <= 1'b0;
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_read    = (state_q == S_FETCH);
  assign pc_en       = (state_q == S_WRITEBACK);
  assign res_valid   = (state_q == S_WRITEBACK);
  assign halted      = (state_q == S_HALT);
  assign ir          = ir_q;
  assign alu_op      = alu_op_q;
  assign res_q       = result_q;
  assign flags_q     = flag_q;
  assign fault       = fault_q;
  assign instr_count = count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed-plus-random bench for cpu_sequencer; expectations come from an
// instruction-level model of fetch waits, decode, writeback and halting.
module tb_cpu_sequencer;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] instr = 32'd0;
  logic [31:0] alu_result = 32'd0;
  logic        alu_neg = 1'b0;
  logic        alu_zero = 1'b0;
  logic        mem_read;
  logic        pc_en;
  logic [31:0] ir;
  logic [3:0]  alu_op;
  logic [31:0] res_q;
  logic [1:0]  flags_q;
  logic        res_valid;
  logic        halted;
  logic        fault;
  logic [15:0] instr_count;
  logic [2:0]  dbg_state;

  cpu_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .mem_ready(mem_ready),
    .instr(instr), .alu_result(alu_result), .alu_neg(alu_neg), .alu_zero(alu_zero),
    .mem_read(mem_read), .pc_en(pc_en), .ir(ir), .alu_op(alu_op),
    .res_q(res_q), .flags_q(flags_q), .res_valid(res_valid), .halted(halted),
    .fault(fault), .instr_count(instr_count), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Instruction-level model state
  logic [31:0] m_ir;
  logic [3:0]  m_op;
  logic [31:0] m_res;
  logic [1:0]  m_flags;
  logic [15:0] m_count;
  logic        m_fault;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_clear();
    m_ir = 32'd0; m_op = 4'd0; m_res = 32'd0; m_flags = 2'd0; m_count = 16'd0; m_fault = 1'b0;
  endtask

  task automatic check_cycle(input string tag, input logic e_mr, input logic e_pc,
                             input logic e_rv, input logic e_h);
    chk({tag, ".mem_read"},    32'(mem_read),    32'(e_mr));
    chk({tag, ".pc_en"},       32'(pc_en),       32'(e_pc));
    chk({tag, ".res_valid"},   32'(res_valid),   32'(e_rv));
    chk({tag, ".halted"},      32'(halted),      32'(e_h));
    chk({tag, ".ir"},          ir,               m_ir);
    chk({tag, ".alu_op"},      32'(alu_op),      32'(m_op));
    chk({tag, ".res_q"},       res_q,            m_res);
    chk({tag, ".flags_q"},     32'(flags_q),     32'(m_flags));
    chk({tag, ".instr_count"}, 32'(instr_count), 32'(m_count));
    chk({tag, ".fault"},       32'(fault),       32'(m_fault));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [3:0] op;
    op = 4'($urandom_range(0, 14));
    return {op, 28'($urandom)};
  endfunction

  // Driver + model for one instruction, entered at the first FETCH cycle.
  // Busy-cycle start pulses and off-FETCH mem_ready are random noise that must be ignored.
  task automatic run_instr(input string tag, input logic [31:0] ins, input int waits,
                           input logic [31:0] res, input logic neg, input logic zero);
    for (int w = 0; w < waits; w++) begin
      check_cycle({tag, ".wait"}, 1'b1, 1'b0, 1'b0, 1'b0);
      mem_ready = 1'b0; instr = $urandom; start = 1'($urandom);
      tick();
    end
    check_cycle({tag, ".fetch"}, 1'b1, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'b1; instr = ins; start = 1'($urandom);
    tick();
    m_ir = ins;
    check_cycle({tag, ".decode"}, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'($urandom); instr = $urandom; start = 1'($urandom);
    tick();
    m_op = ins[31:28];
    start = 1'b0;
    if (ins[31:28] == 4'hF) return;
    check_cycle({tag, ".execute"}, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'($urandom); instr = $urandom; alu_result = $urandom; start = 1'($urandom);
    tick();
    check_cycle({tag, ".writeback"}, 1'b0, 1'b1, 1'b1, 1'b0);
    mem_ready = 1'($urandom); alu_result = res; alu_neg = neg; alu_zero = zero; start = 1'($urandom);
    tick();
    m_res = res; m_flags = {neg, zero};
    if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
    start = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    // Reset state, with start and mem_ready active to show reset wins
    model_clear();
    reset = 1'b0; start = 1'b1; mem_ready = 1'b1;
    tick(); tick();
    check_cycle("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1; start = 1'b0; mem_ready = 1'b1;
    tick();
    check_cycle("idle_hold", 1'b0, 1'b0, 1'b0, 1'b0);

    // Basic instruction: 4 cycles, alu_op 2, result 7
    start = 1'b1;
    tick();
    start = 1'b0;
    run_instr("basic", 32'h2000_0005, 0, 32'd7, 1'b0, 1'b0);
    chk("basic.alu_op", 32'(alu_op), 32'h2);
    chk("basic.res_q", res_q, 32'd7);
    chk("basic.count", 32'(instr_count), 32'd1);

    // Three wait cycles, then boundary of TIMEOUT-1 waits with no fault
    run_instr("wait3", rand_instr(), 3, $urandom, 1'b1, 1'b0);
    run_instr("wait14", rand_instr(), TO - 1, $urandom, 1'b0, 1'b1);

    // Random instruction stream
    for (int k = 0; k < 20; k++) begin
      run_instr("rand", rand_instr(), $urandom_range(0, 5), $urandom, 1'($urandom), 1'($urandom));
    end

    // Fetch timeout into HALT with fault, then resume
    for (int w = 0; w < TO; w++) begin
      check_cycle("to.wait", 1'b1, 1'b0, 1'b0, 1'b0);
      mem_ready = 1'b0; instr = $urandom;
      tick();
    end
    m_fault = 1'b1;
    for (int h = 0; h < 3; h++) begin
      check_cycle("to.halt", 1'b0, 1'b0, 1'b0, 1'b1);
      mem_ready = 1'($urandom); instr = $urandom;
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    m_fault = 1'b0;
    run_instr("resume", rand_instr(), TO - 1, $urandom, 1'b1, 1'b1);

    // HALT opcode: no retire, parks in HALT
    run_instr("hop", 32'hF000_0000, 1, 32'd0, 1'b0, 1'b0);
    for (int h = 0; h < 2; h++) begin
      check_cycle("hop.halt", 1'b0, 1'b0, 1'b0, 1'b1);
      mem_ready = 1'b1;
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;

    // Reset during EXECUTE
    check_cycle("rx.fetch", 1'b1, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'b1; instr = 32'h3123_4567;
    tick();
    m_ir = 32'h3123_4567;
    check_cycle("rx.decode", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    m_op = 4'h3;
    check_cycle("rx.execute", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0; start = 1'b1;
    tick();
    model_clear();
    check_cycle("rx.reset", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1; start = 1'b0;
    tick();
    check_cycle("rx.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;

    // Saturation: preload the retired count just below the limit
    mem_ready = 1'b0;
    force dut.count_q = 16'hFFFE;
    #1;
    release dut.count_q;
    m_count = 16'hFFFE;
    for (int k = 0; k < 3; k++) begin
      run_instr("sat", rand_instr(), 0, $urandom, 1'($urandom), 1'($urandom));
    end
    chk("sat.count", 32'(instr_count), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
